// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the UART receive FIFO and its producer/consumer.
// The slave side is the FIFO; the master side drives receive strobes and pops.
interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic          rx_done;
  logic [7:0]    rx_data;
  logic          parity_error;
  logic          rd_en;
  logic          clr;
  logic          clr_overrun;
  logic [7:0]    rd_data;
  logic          rd_perr;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overrun;
  logic          rts_n;

  modport slave (
    input  rx_done, rx_data, parity_error, rd_en, clr, clr_overrun,
    output rd_data, rd_perr, rd_valid, empty, full, count, overrun, rts_n
  );

  modport master (
    output rx_done, rx_data, parity_error, rd_en, clr, clr_overrun,
    input  rd_data, rd_perr, rd_valid, empty, full, count, overrun, rts_n
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: queues {parity_error, rx_data} per completed character,
// registered pop, sticky overrun and RTS flow control from the fill level.
module uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int RTS_MARGIN = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_fifo_if.slave  bus
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] RTS_LVL  = (AW+1)'(DEPTH - RTS_MARGIN);

  logic [8:0]    mem [DEPTH];
  logic          wr_stb;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          wr_acc;
  logic          rd_acc;
  logic          drop;
  logic [7:0]    rd_data;
  logic          rd_perr;
  logic          rd_valid;
  logic          overrun;
  logic          rts_n;

  // Read acceptance uses the pre-write count, so a write into an empty
  // FIFO is not readable in the same cycle.
  always_comb begin
    rd_acc    = bus.rd_en && (count != '0) && !bus.clr;
    wr_acc    = wr_stb && ((count < FULL_CNT) || rd_acc) && !bus.clr;
    drop      = wr_stb && !wr_acc && !bus.clr;
    count_nxt = count;
    if (bus.clr)
      count_nxt = '0;
    else if (wr_acc && !rd_acc)
      count_nxt = count + (AW+1)'(1);
    else if (rd_acc && !wr_acc)
      count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_stb   <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_perr  <= 1'b0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
      rts_n    <= 1'b0;
    end else begin
      wr_stb   <= bus.rx_done;
      count    <= count_nxt;
      rd_valid <= rd_acc;
      rts_n    <= (count_nxt >= RTS_LVL);
      if (bus.clr) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_acc) wptr <= wptr + AW'(1);
        if (rd_acc) rptr <= rptr + AW'(1);
      end
      if (rd_acc) {rd_perr, rd_data} <= mem[rptr];
      if (bus.clr)
        overrun <= 1'b0;
      else if (drop)
        overrun <= 1'b1;
      else if (bus.clr_overrun)
        overrun <= 1'b0;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= {bus.parity_error, bus.rx_data};
  end

  assign bus.rd_data  = rd_data;
  assign bus.rd_perr  = rd_perr;
  assign bus.rd_valid = rd_valid;
  assign bus.count    = count;
  assign bus.empty    = (count == '0);
  assign bus.full     = (count == FULL_CNT);
  assign bus.overrun  = overrun;
  assign bus.rts_n    = rts_n;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH      = 16;
  localparam int AW         = 4;
  localparam int RTS_MARGIN = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  uart_rx_fifo_if #(.AW(AW)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .RTS_MARGIN(RTS_MARGIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [8:0] mq[$];
  bit         m_pend;
  bit         m_ovr;
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_perr;
  bit         m_rts;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("count",    32'(bus.count),    32'(mq.size()));
    chk("empty",    32'(bus.empty),    32'(mq.size() == 0));
    chk("full",     32'(bus.full),     32'(mq.size() == DEPTH));
    chk("overrun",  32'(bus.overrun),  32'(m_ovr));
    chk("rts_n",    32'(bus.rts_n),    32'(m_rts));
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
    chk("rd_data",  32'(bus.rd_data),  32'(m_data));
    chk("rd_perr",  32'(bus.rd_perr),  32'(m_perr));
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend  = 0;
    m_ovr   = 0;
    m_valid = 0;
    m_data  = 8'h00;
    m_perr  = 0;
    m_rts   = 0;
  endtask

  // One clock: inputs currently on the bus are what the edge sees.
  task automatic cycle();
    bit         i_done, i_perr, i_rd, i_clr, i_clro, rd_ok, wr_ok;
    logic [7:0] i_data;
    logic [8:0] e;
    i_done = bus.rx_done;
    i_data = bus.rx_data;
    i_perr = bus.parity_error;
    i_rd   = bus.rd_en;
    i_clr  = bus.clr;
    i_clro = bus.clr_overrun;
    @(posedge clk);
    #1;
    if (i_clr) begin
      mq.delete();
      m_ovr   = 0;
      m_valid = 0;
    end else begin
      rd_ok = i_rd && (mq.size() > 0);
      wr_ok = m_pend && ((mq.size() < DEPTH) || rd_ok);
      m_valid = rd_ok;
      if (rd_ok) begin
        e      = mq.pop_front();
        m_data = e[7:0];
        m_perr = e[8];
      end
      if (wr_ok) mq.push_back({i_perr, i_data});
      if (m_pend && !wr_ok) m_ovr = 1;
      else if (i_clro)      m_ovr = 0;
    end
    m_pend = i_done;
    m_rts  = (mq.size() >= DEPTH - RTS_MARGIN);
    check_all();
  endtask

  task automatic idle_inputs();
    bus.rx_done      = 1'b0;
    bus.rx_data      = 8'h00;
    bus.parity_error = 1'b0;
    bus.rd_en        = 1'b0;
    bus.clr          = 1'b0;
    bus.clr_overrun  = 1'b0;
  endtask

  // Strobe now; the character is presented in the following (write) cycle.
  task automatic write_char(input logic [7:0] d, input bit p);
    bus.rx_done = 1'b1;
    bus.rx_data = ~d;
    cycle();
    bus.rx_done      = 1'b0;
    bus.rx_data      = d;
    bus.parity_error = p;
    cycle();
    bus.parity_error = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.rd_en = 1'b1;
    repeat (n) cycle();
    bus.rd_en = 1'b0;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < DEPTH; i++) write_char(8'(i), i == 7);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    cycle();

    // Single character
    write_char(8'hA5, 1'b0);
    drain(1);
    cycle();

    // Ordering, parity and wrap-around, three passes
    for (int r = 0; r < 3; r++) begin
      fill_seq();
      drain(DEPTH + 1);
    end

    // Overrun while full, then clear it
    fill_seq();
    write_char(8'h55, 1'b0);
    bus.clr_overrun = 1'b1;
    cycle();
    bus.clr_overrun = 1'b0;
    cycle();
    drain(DEPTH + 1);

    // Full with a write landing on an accepted pop
    fill_seq();
    bus.rx_done = 1'b1;
    cycle();
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h99;
    bus.rd_en   = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
    cycle();
    drain(DEPTH + 1);

    // Empty read, then flush after five entries
    drain(3);
    for (int i = 0; i < 5; i++) write_char(8'(8'hC0 + i), i[0]);
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
    cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.rx_done      = ($urandom_range(0, 99) < 45);
      bus.rx_data      = 8'($urandom);
      bus.parity_error = ($urandom_range(0, 99) < 20);
      bus.rd_en        = ($urandom_range(0, 99) < 35);
      bus.clr          = ($urandom_range(0, 99) < 2);
      bus.clr_overrun  = ($urandom_range(0, 99) < 5);
      cycle();
    end
    idle_inputs();
    cycle();

    // Asynchronous reset mid-fill with a strobe in flight
    for (int i = 0; i < 6; i++) write_char(8'(8'h30 + i), 1'b0);
    drain(2);
    bus.rx_done = 1'b1;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    bus.rx_done = 1'b0;
    rst_n = 1'b1;
    check_all();
    repeat (3) cycle();
    write_char(8'h3C, 1'b1);
    drain(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between `uart_rx` and the bus/register interface. It captures each completed character together with its parity-error flag and queues it in a circular FIFO. The consumer pops entries with a registered read. The block also flags overruns and generates an RTS flow-control signal from the fill level.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, at least 2.
- `AW`, 4, address width; equals log2(`DEPTH`).
- `RTS_MARGIN`, 4, free-entry threshold for deasserting flow control; 1 ≤ `RTS_MARGIN` < `DEPTH`.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_done` in 1: character-complete strobe from `uart_rx`.
- `rx_data` in 8: received character; unused upper bits are zero for 5–7-bit frames.
- `parity_error` in 1: parity result for the same character.
- `rd_en` in 1: pop request, one entry per cycle.
- `clr` in 1: synchronous flush of contents, pointers and `overrun`.
- `clr_overrun` in 1: clears the sticky `overrun` flag.
- `rd_data` out 8: popped character.
- `rd_perr` out 1: parity flag of the popped character.
- `rd_valid` out 1: one-cycle pulse; `rd_data` and `rd_perr` are valid in that cycle.
- `empty` out 1: count == 0.
- `full` out 1: count == `DEPTH`.
- `count` out AW+1: current occupancy.
- `overrun` out 1: sticky flag; a character was dropped.
- `rts_n` out 1: 0 means the sender may transmit; 1 means hold off.

## Operation
- **Write strobe.** `rx_done` is registered into `wr_stb`. The write uses `rx_data` and `parity_error` as sampled in the `wr_stb` cycle, one clock after `rx_done`. This covers `uart_rx` updating `rx_data` on the same edge it pulses done.
- **Strobe length.** A `rx_done` held high for N cycles produces N writes. The upstream block guarantees single-cycle pulses.
- **Storage.** Each entry is 9 bits, {perr, data[7:0]}, held in a `DEPTH`-entry array.
- **Pointers.** `wptr` and `rptr` are AW bits and wrap modulo `DEPTH`. A separate `count` register (AW+1 bits) distinguishes full from empty.
- **Write acceptance.** A write is accepted if `count < DEPTH`, or if a pop is accepted in the same cycle. Otherwise the character is dropped and `overrun` is set.
- **Read acceptance.** A read is accepted if `rd_en` is high and `count > 0`. A read while empty is ignored: no `rd_valid`, no pointer change.
- **Count update.**
  - Write only: +1.
  - Read only: −1.
  - Both accepted: unchanged.
- **Read data path.** On an accepted read, the entry at `rptr` is registered into `rd_data`/`rd_perr` and `rd_valid` pulses on the next cycle. Outside a read, `rd_data`/`rd_perr` hold their last value.
- **Flow control.** `rts_n` is registered: 1 when `count >= DEPTH - RTS_MARGIN`, else 0. The comparison uses the next-cycle count.
- **Overrun flag.** Set by a dropped write; cleared by `clr_overrun`. If both happen in the same cycle, set wins.
- **Flush.** `clr` zeros `wptr`, `rptr`, `count` and `overrun`, and cancels any same-cycle write and read.
  - `rd_valid` is 0 in the cycle after `clr`.
  - `wr_stb` is not cleared; a `rx_done` in the cycle before `clr` is lost.
- **Reset values.** All outputs, `wr_stb` and pointers reset to 0, except `empty`=1. `full`=0, `rts_n`=0. Array contents are not reset.

## Timing
- **Write latency.** `rx_done` at edge k → `wr_stb` at k+1 → entry stored and `count` incremented at k+2. `empty` falls and `rts_n` updates at k+2.
- **Read latency.** `rd_en` sampled at edge k → `rd_data`, `rd_perr` and `rd_valid` registered at k+1 (one cycle). `count` decrements at k+1.
- **Back-to-back reads.** `rd_en` held high drains one entry per cycle until empty. `rd_valid` stays high for exactly `count` cycles.
- **Write into empty, read in the same cycle.** The read is rejected because the count check uses the pre-write count. The data becomes readable the following cycle.
- **Full with simultaneous write and pop.** Both are accepted and `count` stays `DEPTH`. `overrun` is not set.
- **Reset mid-operation.** Asynchronous reset clears state immediately and no `rd_valid` is produced. Any character in `wr_stb` is lost.

## Test plan
- **Single character.** Reset, pulse `rx_done` with `rx_data`=0xA5, `parity_error`=0 → `count`=1 and `empty`=0 two cycles later. Then `rd_en` for one cycle → next cycle `rd_valid`=1, `rd_data`=0xA5, `rd_perr`=0, `empty`=1.
- **Ordering, parity and wrap-around.**
  - Write 0x00–0x0F with `parity_error`=1 on 0x07 only. `count` reaches 16 and `full`=1.
  - Drain all 16: data comes out in order, with `rd_perr`=1 only on 0x07.
  - Repeat 3 times: pointers wrap with no corruption.
- **Overrun.** With the FIFO full, write 0x55 → `overrun`=1, `count`=16, and 0x55 never appears on read. `clr_overrun` → `overrun`=0.
- **Full plus simultaneous pop.** With the FIFO full, strobe a write of 0x99 timed to coincide with an accepted pop → `count` stays 16, `overrun`=0, and 0x99 is read last.
- **Flow control.** `DEPTH`=16, `RTS_MARGIN`=4: `rts_n` rises when `count` reaches 12 and falls when `count` returns to 11.
- **Empty read and flush.**
  - `rd_en` while empty → no `rd_valid`, `count` stays 0.
  - Fill 5 entries then pulse `clr` → `count`=0, `empty`=1, `overrun`=0.
  - Assert `rst_n`=0 mid-fill → all outputs at reset values within the same cycle.
